key_led_sequencer: RTL and testbench

Mode controller that sequences the 8-bit active-low LED bank under control of four debounced key-press events. It sits downstream of the key debounce stage, which supplies one-cycle press pulses. It owns the LED pattern generator (running, ping-pong, blink), its step prescaler and a pause/resume control. Simultaneous key events are arbitrated by fixed priority.

---
 rtl/key_led_sequencer.sv | 110 +++++++++++
 tb/tb_key_led_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/key_led_sequencer.sv
// LED bank sequencer: running, ping-pong and blink patterns
// selected by prioritised key events, with pause/resume.
module key_led_sequencer #(
  parameter logic [24:0] STEP_MAX = 25'd24_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_evt,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       step
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_BOUNCE = 2'd2,
    S_BLINK  = 2'd3
  } mode_t;

  mode_t       r_mode;
  logic [7:0]  r_led;
  logic        r_paused;
  logic        r_step;
  logic        r_dir;
  logic [24:0] r_cnt;
  logic [2:0]  r_pos;

  logic        w_sel;
  mode_t       w_sel_mode;
  logic [2:0]  w_pos_nxt;
  logic        w_dir_nxt;
  logic        w_active;

  assign w_sel    = |key_evt[2:0];
  assign w_active = (r_mode != S_IDLE) && !r_paused;

  always_comb begin
    w_sel_mode = S_BLINK;
    if (key_evt[0])
      w_sel_mode = S_RUN;
    else if (key_evt[1])
      w_sel_mode = S_BOUNCE;
  end

  // dir 0 = up; bounce turns around at both ends
  always_comb begin
    w_pos_nxt = r_pos + 3'd1;
    w_dir_nxt = r_dir;
    if (r_mode == S_BOUNCE) begin
      if (!r_dir) begin
        if (r_pos == 3'd7) begin
          w_dir_nxt = 1'b1;
          w_pos_nxt = 3'd6;
        end
      end else if (r_pos == 3'd0) begin
        w_dir_nxt = 1'b0;
        w_pos_nxt = 3'd1;
      end else begin
        w_pos_nxt = r_pos - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= S_IDLE;
      r_led    <= 8'hFF;
      r_paused <= 1'b0;
      r_step   <= 1'b0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
      r_pos    <= '0;
    end else begin
      r_step <= 1'b0;
      if (w_sel) begin
        r_mode   <= w_sel_mode;
        r_paused <= 1'b0;
        r_cnt    <= '0;
        r_pos    <= '0;
        r_dir    <= 1'b0;
        r_led    <= (w_sel_mode == S_BLINK) ? 8'h00 : 8'hFE;
      end else if (key_evt[3]) begin
        if (r_mode != S_IDLE)
          r_paused <= ~r_paused;
      end else if (w_active) begin
        if (r_cnt == STEP_MAX) begin
          r_cnt  <= '0;
          r_step <= 1'b1;
          if (r_mode == S_BLINK) begin
            r_led <= ~r_led;
          end else begin
            r_pos <= w_pos_nxt;
            r_dir <= w_dir_nxt;
            r_led <= ~(8'h01 << w_pos_nxt);
          end
        end else begin
          r_cnt <= r_cnt + 25'd1;
        end
      end
    end
  end

  assign led    = r_led;
  assign mode   = r_mode;
  assign paused = r_paused;
  assign step   = r_step;

endmodule

// File: tb/tb_key_led_sequencer.sv
// Self-checking bench for key_led_sequencer (STEP_MAX=3)
// against a tick-count reference model.
module tb_key_led_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] key_evt;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       step;

  int nassert = 0;
  int nfail   = 0;

  key_led_sequencer #(.STEP_MAX(25'd3)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_evt (key_evt),
    .led     (led),
    .mode    (mode),
    .paused  (paused),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: mode, pause flag, prescaler count, ticks since select
  logic [1:0] m_mode;
  logic       m_paused;
  logic       m_step;
  int         m_cnt;
  int         m_k;
  logic [7:0] one8 = 8'h01;

  function automatic logic [7:0] exp_led();
    int p;
    int lit;
    case (m_mode)
      2'd1: return ~(one8 << (m_k % 8));
      2'd2: begin
        p   = m_k % 14;
        lit = (p <= 7) ? p : 14 - p;
        return ~(one8 << lit);
      end
      2'd3: return (m_k % 2 == 1) ? 8'hFF : 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic m_reset();
    m_mode   = 2'd0;
    m_paused = 1'b0;
    m_step   = 1'b0;
    m_cnt    = 0;
    m_k      = 0;
  endtask

  task automatic m_select(input logic [1:0] md);
    m_mode   = md;
    m_paused = 1'b0;
    m_cnt    = 0;
    m_k      = 0;
  endtask

  task automatic m_edge(input logic [3:0] evt);
    m_step = 1'b0;
    if (evt[0])      m_select(2'd1);
    else if (evt[1]) m_select(2'd2);
    else if (evt[2]) m_select(2'd3);
    else if (evt[3]) begin
      if (m_mode != 2'd0) m_paused = !m_paused;
    end else if (m_mode != 2'd0 && !m_paused) begin
      if (m_cnt == 3) begin
        m_cnt  = 0;
        m_k    = m_k + 1;
        m_step = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("led", led, exp_led());
    chk("mode", {6'd0, mode}, {6'd0, m_mode});
    chk("paused", {7'd0, paused}, {7'd0, m_paused});
    chk("step", {7'd0, step}, {7'd0, m_step});
  endtask

  task automatic cyc(input logic [3:0] evt);
    key_evt = evt;
    m_edge(evt);
    @(posedge clk);
    #1;
    key_evt = 4'd0;
    check_all();
  endtask

  logic [7:0] run_exp [8];
  int         bseq [16];
  logic [3:0] revt;
  int         j;

  initial begin
    run_exp = '{8'hFD, 8'hFB, 8'hF7, 8'hEF,
                8'hDF, 8'hBF, 8'h7F, 8'hFE};
    bseq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    rst     = 1'b1;
    key_evt = 4'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    cyc(4'b0000);

    // RUN sequence
    cyc(4'b0001);
    chk("run_first", led, 8'hFE);
    chk("run_mode", {6'd0, mode}, 8'd1);
    j = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(4'b0000);
      if (m_step && j < 8) begin
        chk("run_seq", led, run_exp[j]);
        j++;
      end
    end

    // BOUNCE turn-around
    cyc(4'b0010);
    chk("bounce_first", led, 8'hFE);
    j = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(4'b0000);
      if (m_step && j < 16) begin
        chk("bounce_seq", led, ~(one8 << bseq[j]));
        j++;
      end
    end

    // pause two clocks after a BLINK toggle
    cyc(4'b0100);
    chk("blink_first", led, 8'h00);
    repeat (4) cyc(4'b0000);
    chk("blink_toggle", led, 8'hFF);
    repeat (2) cyc(4'b0000);
    cyc(4'b1000);
    chk("pause_on", {7'd0, paused}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0000);
      chk("pause_frozen", led, 8'hFF);
    end
    cyc(4'b1000);
    chk("pause_off", {7'd0, paused}, 8'd0);
    cyc(4'b0000);
    chk("resume_wait", {7'd0, step}, 8'd0);
    cyc(4'b0000);
    chk("resume_tick", {7'd0, step}, 8'd1);
    chk("resume_led", led, 8'h00);

    // priority and event/tick collision
    cyc(4'b1110);
    chk("prio_mode", {6'd0, mode}, 8'd2);
    chk("prio_led", led, 8'hFE);
    chk("prio_paused", {7'd0, paused}, 8'd0);
    repeat (3) cyc(4'b0000);
    cyc(4'b0100);
    chk("coll_mode", {6'd0, mode}, 8'd3);
    chk("coll_led", led, 8'h00);
    chk("coll_step", {7'd0, step}, 8'd0);
    repeat (3) cyc(4'b0000);
    chk("coll_quiet", led, 8'h00);
    cyc(4'b0000);
    chk("coll_next", led, 8'hFF);
    chk("coll_step2", {7'd0, step}, 8'd1);

    // random events
    for (int i = 0; i < 400; i++) begin
      revt = 4'd0;
      if ($urandom_range(0, 5) == 0)
        revt = 4'($urandom_range(0, 15));
      cyc(revt);
    end

    // asynchronous reset mid-BLINK
    cyc(4'b0100);
    repeat (5) cyc(4'b0000);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check_all();
    chk("async_led", led, 8'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b1000);
    chk("idle_pause", {7'd0, paused}, 8'd0);
    repeat (4) cyc(4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
